decode_stage: RTL and testbench
===============================

Name: decode_stage

Overview:
- Parametrised, registered successor of the single-instruction combinational decoder.
- Decodes up to WIDTH RV32I instructions per cycle, each lane with its own valid mask.
- Holds results in a 2-entry skid buffer with valid/ready handshake on both sides, plus pipeline flush.
- Sits between fetch and rename/issue.

Parameters:
WIDTH, 2, number of decode lanes (1..4); lane 0 occupies the least-significant slice of every packed bus.

Ports:
i_clk  input  1  clock, rising edge
i_rst_n  input  1  reset, synchronous, active-low
i_flush  input  1  discard all buffered and incoming bundles
i_valid  input  1  fetch bundle present
o_ready  output  1  stage can accept a bundle
i_instr  input  32*WIDTH  instruction per lane
i_imask  input  WIDTH  per-lane instruction valid
o_valid  output  1  decoded bundle present
i_ready  input  1  consumer accepts bundle
o_lmask  output  WIDTH  per-lane valid of output bundle
o_regs  output  15*WIDTH  per lane {rd, rs2, rs1}
o_func  output  10*WIDTH  per lane {funct7, funct3}
o_ctrl  output  5*WIDTH  per lane {illegal, reg_write, mem_read, mem_write, branch_jump}
o_imm  output  32*WIDTH  per lane sign-extended immediate

Behaviour:
- Reset (i_rst_n=0 at posedge): both skid entries empty. o_valid=0, o_lmask=0, all data outputs 0, o_ready=1 on the following cycle. Reset mid-transfer drops everything.
- Per-lane decode:
  - regs fields are raw bit slices: rd=[11:7], rs2=[24:20], rs1=[19:15].
  - func = {funct7, funct3} for R-type; {7'b0, funct3} for I/S/B; 0 for U/J.
  - imm follows RV32I I/S/B/U/J formats, sign-extended from bit 31; 0 for R-type.
- ctrl:
  - reg_write = (opcode writes rd) && rd!=0.
  - mem_read = LOAD; mem_write = STORE; branch_jump = BRANCH/JAL/JALR.
  - illegal = unknown opcode; when set, all other ctrl bits are 0.
- Masked lanes: a lane with i_imask=0 stores all-zero regs/func/ctrl/imm and lmask=0.
- Handshake:
  - Accept when i_valid && o_ready.
  - Output transfer when o_valid && i_ready.
  - Latency: an accepted bundle appears on the outputs the cycle after acceptance.
- Skid buffer:
  - Entry 0 drives the outputs.
  - Entry 1 catches a bundle accepted while entry 0 stalls.
  - o_ready = !entry1_valid (registered, no combinational path from i_ready).
  - Accept and transfer in the same cycle with only entry 0 full: entry 0 is replaced, with no bubble.
  - Transfer with both entries full: entry 1 moves to entry 0, and o_ready rises next cycle.
- Flush: i_flush=1 at a posedge empties both entries and ignores i_valid that cycle; o_valid=0 the next cycle. Flush has priority over accept and transfer. Reset has priority over flush.
- Ordering: strict FIFO; bundles are never reordered or dropped except by flush or reset.

Decomposition:
- Package decode_pkg: RV32I opcode constants (OP, OP_IMM, LOAD, STORE, BRANCH, JAL, JALR, LUI, AUIPC, SYSTEM, MISC_MEM); ctrl bit index constants; field width constants (REG_W=15, FUNC_W=10, CTRL_W=5).
- Sub-module decode_lane: combinational decode of one instruction plus mask. It is instantiated WIDTH times via generate.
- The skid buffer stays in decode_stage.

Test Plan:
- Single lane: WIDTH=2, i_valid=1, lanes {0xfe010113, 0x00112e23}, i_imask=2'b11, i_ready=1. Next cycle:
  - lane0 regs {rd=2, rs2=0, rs1=2}, imm=0xffffffe0, func=0, ctrl=5'b01000.
  - lane1 rs1=2, rs2=1, imm=0x0000001c, func=10'h002, ctrl=5'b00010.
- Masking and jump: lanes {0x01c0006f, 0x00000000}, i_imask=2'b01.
  - lane0 imm=0x1c, ctrl=5'b00001 (rd=x0, so no reg_write).
  - lane1 all zero; o_lmask=2'b01.
- Illegal opcode: lane0 = 0xffffffff, i_imask=1 -> ctrl=5'b10000.
- Backpressure: hold i_ready=0 and present 3 bundles back-to-back.
  - First two are accepted; o_ready=0 after the second.
  - Third is held by fetch.
  - Raise i_ready: outputs deliver bundles 1, 2, 3 in order on consecutive cycles, none lost.
- Flush: with both entries full, pulse i_flush with i_valid=1 -> o_valid=0 next cycle, o_ready=1, and the flush-cycle bundle is never output.
- Reset mid-operation: assert i_rst_n=0 for one posedge with entries full -> o_valid=0, all outputs 0, o_ready=1 afterwards.

Source files
------------

// File: rtl/decode_pkg.sv
// Shared constants and types for the RV32I decode stage.
package decode_pkg;

  // RV32I major opcodes
  localparam logic [6:0] OP       = 7'b0110011;
  localparam logic [6:0] OP_IMM   = 7'b0010011;
  localparam logic [6:0] LOAD     = 7'b0000011;
  localparam logic [6:0] STORE    = 7'b0100011;
  localparam logic [6:0] BRANCH   = 7'b1100011;
  localparam logic [6:0] JAL      = 7'b1101111;
  localparam logic [6:0] JALR     = 7'b1100111;
  localparam logic [6:0] LUI      = 7'b0110111;
  localparam logic [6:0] AUIPC    = 7'b0010111;
  localparam logic [6:0] SYSTEM   = 7'b1110011;
  localparam logic [6:0] MISC_MEM = 7'b0001111;

  // ctrl bit positions: {illegal, reg_write, mem_read, mem_write, branch_jump}
  localparam int CTRL_ILL = 4;
  localparam int CTRL_RW  = 3;
  localparam int CTRL_MR  = 2;
  localparam int CTRL_MW  = 1;
  localparam int CTRL_BJ  = 0;

  // per-lane field widths
  localparam int REG_W  = 15;
  localparam int FUNC_W = 10;
  localparam int CTRL_W = 5;
  localparam int XLEN   = 32;

  // instruction encoding format; FMT_X marks an unknown opcode
  typedef enum logic [2:0] {FMT_R, FMT_I, FMT_S, FMT_B, FMT_U, FMT_J, FMT_X} fmt_e;

  // decoded result of one lane
  typedef struct packed {
    logic [REG_W-1:0]  regs;  // {rd, rs2, rs1}
    logic [FUNC_W-1:0] func;  // {funct7, funct3}
    logic [CTRL_W-1:0] ctrl;
    logic [XLEN-1:0]   imm;
  } lane_dec_t;

  // sign-extended immediate for the given format; R-type and unknown give 0
  function automatic logic [XLEN-1:0] imm_gen(input fmt_e fmt, input logic [31:0] ins);
    logic [XLEN-1:0] imm;
    imm = '0;
    case (fmt)
      FMT_I:   imm = {{20{ins[31]}}, ins[31:20]};
      FMT_S:   imm = {{20{ins[31]}}, ins[31:25], ins[11:7]};
      FMT_B:   imm = {{19{ins[31]}}, ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
      FMT_U:   imm = {ins[31:12], 12'b0};
      FMT_J:   imm = {{11{ins[31]}}, ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
      default: imm = '0;
    endcase
    return imm;
  endfunction

endpackage

// File: rtl/decode_lane.sv
// Combinational RV32I decode of a single instruction slot, gated by its mask.
module decode_lane
  import decode_pkg::*;
(
  input  logic [31:0] instr,
  input  logic        en,
  output lane_dec_t   dec
);

  logic [6:0] opc;
  logic [4:0] rd;
  logic [2:0] f3;
  fmt_e       fmt;
  logic       wr, mr, mw, bj, ill;

  assign opc = instr[6:0];
  assign rd  = instr[11:7];
  assign f3  = instr[14:12];

  // classify opcode into format and raw control flags
  always_comb begin
    fmt = FMT_X;
    wr  = 1'b0;
    mr  = 1'b0;
    mw  = 1'b0;
    bj  = 1'b0;
    ill = 1'b0;
    case (opc)
      OP:       begin fmt = FMT_R; wr = 1'b1; end
      OP_IMM:   begin fmt = FMT_I; wr = 1'b1; end
      LOAD:     begin fmt = FMT_I; wr = 1'b1; mr = 1'b1; end
      STORE:    begin fmt = FMT_S; mw = 1'b1; end
      BRANCH:   begin fmt = FMT_B; bj = 1'b1; end
      JAL:      begin fmt = FMT_J; wr = 1'b1; bj = 1'b1; end
      JALR:     begin fmt = FMT_I; wr = 1'b1; bj = 1'b1; end
      LUI:      begin fmt = FMT_U; wr = 1'b1; end
      AUIPC:    begin fmt = FMT_U; wr = 1'b1; end
      SYSTEM:   begin fmt = FMT_I; wr = 1'b1; end  // CSR ops write rd; ecall/ebreak have rd=0
      MISC_MEM: begin fmt = FMT_I; end
      default:  begin fmt = FMT_X; ill = 1'b1; end
    endcase
  end

  // assemble lane result; masked lane is all zero
  always_comb begin
    dec = '0;
    if (en) begin
      dec.regs = {rd, instr[24:20], instr[19:15]};
      case (fmt)
        FMT_R:               dec.func = {instr[31:25], f3};
        FMT_I, FMT_S, FMT_B: dec.func = {7'b0, f3};
        default:             dec.func = '0;
      endcase
      dec.imm = imm_gen(fmt, instr);
      if (ill) begin
        dec.ctrl = '0;
        dec.ctrl[CTRL_ILL] = 1'b1;
      end else begin
        dec.ctrl[CTRL_RW] = wr && (rd != 5'd0);
        dec.ctrl[CTRL_MR] = mr;
        dec.ctrl[CTRL_MW] = mw;
        dec.ctrl[CTRL_BJ] = bj;
      end
    end
  end

endmodule

// File: rtl/decode_stage.sv
// WIDTH-lane registered RV32I decode stage with a 2-entry skid buffer and flush.
module decode_stage
  import decode_pkg::*;
#(
  parameter int WIDTH = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst_n,
  input  logic                    i_flush,
  input  logic                    i_valid,
  output logic                    o_ready,
  input  logic [32*WIDTH-1:0]     i_instr,
  input  logic [WIDTH-1:0]        i_imask,
  output logic                    o_valid,
  input  logic                    i_ready,
  output logic [WIDTH-1:0]        o_lmask,
  output logic [REG_W*WIDTH-1:0]  o_regs,
  output logic [FUNC_W*WIDTH-1:0] o_func,
  output logic [CTRL_W*WIDTH-1:0] o_ctrl,
  output logic [XLEN*WIDTH-1:0]   o_imm
);

  typedef struct packed {
    logic [WIDTH-1:0]             lmask;
    lane_dec_t [WIDTH-1:0]        lane;
  } bundle_t;

  bundle_t dec_b, e0, e1;
  logic    v0, v1;
  logic    acc, xfer;

  // per-lane decoders
  for (genvar g = 0; g < WIDTH; g++) begin : g_lane
    decode_lane u_lane (
      .instr (i_instr[32*g +: 32]),
      .en    (i_imask[g]),
      .dec   (dec_b.lane[g])
    );
  end
  assign dec_b.lmask = i_imask;

  // o_ready depends only on the entry-1 flop, never on i_ready
  assign o_ready = ~v1;
  assign acc     = i_valid && o_ready;
  assign xfer    = v0 && i_ready;

  // skid buffer: entry 0 drives outputs, entry 1 catches a stalled accept
  always_ff @(posedge i_clk) begin
    if (!i_rst_n) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      e0 <= '0;
      e1 <= '0;
    end else if (i_flush) begin
      v0 <= 1'b0;
      v1 <= 1'b0;
      e0 <= '0;
      e1 <= '0;
    end else if (xfer || !v0) begin
      // entry 0 is free this cycle; refill from entry 1 first to keep order
      if (v1) begin
        e0 <= e1;
        v0 <= 1'b1;
        e1 <= '0;
        v1 <= 1'b0;
      end else if (acc) begin
        e0 <= dec_b;
        v0 <= 1'b1;
      end else begin
        e0 <= '0;
        v0 <= 1'b0;
      end
    end else if (acc) begin
      e1 <= dec_b;
      v1 <= 1'b1;
    end
  end

  assign o_valid = v0;
  assign o_lmask = e0.lmask;

  // unpack entry 0 into the flat per-lane output buses
  for (genvar g = 0; g < WIDTH; g++) begin : g_out
    assign o_regs[REG_W*g  +: REG_W]  = e0.lane[g].regs;
    assign o_func[FUNC_W*g +: FUNC_W] = e0.lane[g].func;
    assign o_ctrl[CTRL_W*g +: CTRL_W] = e0.lane[g].ctrl;
    assign o_imm[XLEN*g    +: XLEN]   = e0.lane[g].imm;
  end

endmodule

// File: tb/tb_decode_stage.sv
// Directed bench for decode_stage (WIDTH=2) with hand-computed expectations.
module tb_decode_stage;

  localparam int W = 2;

  logic          i_clk = 1'b0;
  logic          i_rst_n, i_flush, i_valid, i_ready;
  logic          o_ready, o_valid;
  logic [63:0]   i_instr;
  logic [1:0]    i_imask, o_lmask;
  logic [29:0]   o_regs;
  logic [19:0]   o_func;
  logic [9:0]    o_ctrl;
  logic [63:0]   o_imm;

  int total = 0;
  int bad   = 0;

  decode_stage #(.WIDTH(W)) dut (
    .i_clk   (i_clk),
    .i_rst_n (i_rst_n),
    .i_flush (i_flush),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .i_instr (i_instr),
    .i_imask (i_imask),
    .o_valid (o_valid),
    .i_ready (i_ready),
    .o_lmask (o_lmask),
    .o_regs  (o_regs),
    .o_func  (o_func),
    .o_ctrl  (o_ctrl),
    .o_imm   (o_imm)
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // advance one rising edge, then settle before sampling/driving
  task automatic step();
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk_zero_out(input string tag);
    chk({tag, ".valid"}, {63'b0, o_valid}, 64'd0);
    chk({tag, ".ready"}, {63'b0, o_ready}, 64'd1);
    chk({tag, ".lmask"}, {62'b0, o_lmask}, 64'd0);
    chk({tag, ".regs"},  {34'b0, o_regs},  64'd0);
    chk({tag, ".func"},  {44'b0, o_func},  64'd0);
    chk({tag, ".ctrl"},  {54'b0, o_ctrl},  64'd0);
    chk({tag, ".imm"},   o_imm,            64'd0);
  endtask

  // lui xK, 0x12345 : distinct rd per bundle
  function automatic logic [31:0] lui_k(input int k);
    logic [31:0] v;
    v = 32'h12345037 | (32'(k) << 7);
    return v;
  endfunction

  initial begin
    i_rst_n = 1'b0; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
    i_instr = '0;   i_imask = '0;
    step(); step();
    i_rst_n = 1'b1;
    chk_zero_out("reset");

    // addi sp,sp,-32 | sw ra,28(sp)
    i_valid = 1'b1; i_imask = 2'b11;
    i_instr = {32'h00112e23, 32'hfe010113};
    step();
    chk("t1.valid", {63'b0, o_valid}, 64'd1);
    chk("t1.lmask", {62'b0, o_lmask}, 64'd3);
    chk("t1.regs0", {49'b0, o_regs[14:0]},  64'h0802);
    chk("t1.imm0",  {32'b0, o_imm[31:0]},   64'hffffffe0);
    chk("t1.func0", {54'b0, o_func[9:0]},   64'h000);
    chk("t1.ctrl0", {59'b0, o_ctrl[4:0]},   64'b01000);
    chk("t1.regs1", {49'b0, o_regs[29:15]}, 64'h7022);
    chk("t1.imm1",  {32'b0, o_imm[63:32]},  64'h1c);
    chk("t1.func1", {54'b0, o_func[19:10]}, 64'h002);
    chk("t1.ctrl1", {59'b0, o_ctrl[9:5]},   64'b00010);

    // jal x0,28 with lane1 masked
    i_instr = {32'h00000000, 32'h01c0006f}; i_imask = 2'b01;
    step();
    chk("t2.lmask", {62'b0, o_lmask}, 64'd1);
    chk("t2.regs0", {49'b0, o_regs[14:0]},  64'h0380);
    chk("t2.imm0",  {32'b0, o_imm[31:0]},   64'h1c);
    chk("t2.func0", {54'b0, o_func[9:0]},   64'h0);
    chk("t2.ctrl0", {59'b0, o_ctrl[4:0]},   64'b00001);
    chk("t2.lane1", {o_regs[29:15], o_func[19:10], o_ctrl[9:5], o_imm[63:32]}, 64'd0);

    // illegal | sub a0,a0,a1
    i_instr = {32'h40b50533, 32'hffffffff}; i_imask = 2'b11;
    step();
    chk("t3.ctrl0", {59'b0, o_ctrl[4:0]},   64'b10000);
    chk("t3.regs1", {49'b0, o_regs[29:15]}, 64'h296a);
    chk("t3.func1", {54'b0, o_func[19:10]}, 64'h100);
    chk("t3.ctrl1", {59'b0, o_ctrl[9:5]},   64'b01000);
    chk("t3.imm1",  {32'b0, o_imm[63:32]},  64'h0);

    // drain
    i_valid = 1'b0;
    step();
    chk("drain.valid", {63'b0, o_valid}, 64'd0);

    // backpressure: three back-to-back bundles with consumer stalled
    i_ready = 1'b0; i_valid = 1'b1; i_imask = 2'b01;
    i_instr = {32'h0, lui_k(1)};
    step();
    chk("bp.b1.valid", {63'b0, o_valid}, 64'd1);
    chk("bp.b1.rd",    {59'b0, o_regs[14:10]}, 64'd1);
    chk("bp.b1.imm",   {32'b0, o_imm[31:0]},   64'h12345000);
    chk("bp.b1.ready", {63'b0, o_ready}, 64'd1);
    i_instr = {32'h0, lui_k(2)};
    step();
    chk("bp.b2.ready", {63'b0, o_ready}, 64'd0);
    chk("bp.b2.rd",    {59'b0, o_regs[14:10]}, 64'd1);
    i_instr = {32'h0, lui_k(3)};
    step();
    chk("bp.b3.ready", {63'b0, o_ready}, 64'd0);
    chk("bp.hold.rd",  {59'b0, o_regs[14:10]}, 64'd1);
    i_ready = 1'b1;
    step();
    chk("bp.o2.valid", {63'b0, o_valid}, 64'd1);
    chk("bp.o2.rd",    {59'b0, o_regs[14:10]}, 64'd2);
    chk("bp.o2.ready", {63'b0, o_ready}, 64'd1);
    step();
    chk("bp.o3.valid", {63'b0, o_valid}, 64'd1);
    chk("bp.o3.rd",    {59'b0, o_regs[14:10]}, 64'd3);
    i_valid = 1'b0;
    step();
    chk("bp.end.valid", {63'b0, o_valid}, 64'd0);

    // flush with both entries full and a bundle offered
    i_ready = 1'b0; i_valid = 1'b1;
    i_instr = {32'h0, lui_k(4)}; step();
    i_instr = {32'h0, lui_k(5)}; step();
    chk("fl.full.ready", {63'b0, o_ready}, 64'd0);
    i_flush = 1'b1; i_instr = {32'h0, lui_k(6)};
    step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk_zero_out("fl");
    i_ready = 1'b1;
    step();
    chk("fl.after.valid", {63'b0, o_valid}, 64'd0);

    // flush with only entry 0 full: offered bundle must still be ignored
    i_valid = 1'b1; i_ready = 1'b0; i_instr = {32'h0, lui_k(7)}; step();
    i_flush = 1'b1; i_instr = {32'h0, lui_k(8)}; step();
    i_flush = 1'b0; i_valid = 1'b0;
    chk("fl1.valid", {63'b0, o_valid}, 64'd0);

    // reset with both entries full
    i_valid = 1'b1;
    i_instr = {32'h0, lui_k(9)};  step();
    i_instr = {32'h0, lui_k(10)}; step();
    chk("rst.full.ready", {63'b0, o_ready}, 64'd0);
    i_rst_n = 1'b0; i_valid = 1'b0;
    step();
    i_rst_n = 1'b1;
    chk_zero_out("rst");

    // stage usable again after reset
    i_ready = 1'b1; i_valid = 1'b1; i_instr = {32'h0, lui_k(11)};
    step();
    i_valid = 1'b0;
    chk("post.rd", {59'b0, o_regs[14:10]}, 64'd11);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
